// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge control FSM.
// Turns qualified AHB transfers into APB setup/access pairs. Outputs are
// registered and chosen by the (current state, next state) pair, so each
// output describes the state being entered on that edge.
//
// Handshake: hreadyout=1 means the bridge accepts the AHB transfer that
// `valid` currently flags; while hreadyout=0 the upstream master holds its
// address phase. The APB side has no pready, so every access completes in
// exactly one setup cycle (penable=0) and one access cycle (penable=1).
`timescale 1ns/1ps
module apb_fsm_controller (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        valid,
    input  logic        hwrite,
    input  logic        hwrite_reg,
    input  logic [31:0] haddr,
    input  logic [31:0] haddr1,
    input  logic [31:0] haddr2,
    input  logic [31:0] hwdata,
    input  logic [31:0] hwdata1,
    input  logic [31:0] hwdata2,
    input  logic [2:0]  temp_selx,
    output logic        pwrite,
    output logic        penable,
    output logic [2:0]  pselx,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        hreadyout,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } state_t;

    state_t state;
    state_t next_state;

    // Two-cycle-old write data is part of the upstream pipeline but never
    // reaches the APB side; fold it into an unused sink so it stays visible.
    logic unused_hwdata2;
    assign unused_hwdata2 = ^hwdata2;

    // Debug view of the current state for checkers.
    assign fsm_state = state;

    // Next-state decode.
    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (valid && hwrite)
                    next_state = ST_WWAIT;
                else if (valid)
                    next_state = ST_READ;
                else
                    next_state = ST_IDLE;
            end
            ST_WWAIT: begin
                next_state = valid ? ST_WRITEP : ST_WRITE;
            end
            ST_READ: begin
                next_state = ST_RENABLE;
            end
            ST_WRITE: begin
                next_state = valid ? ST_WENABLEP : ST_WENABLE;
            end
            ST_WRITEP: begin
                next_state = ST_WENABLEP;
            end
            ST_RENABLE, ST_WENABLE: begin
                if (valid && hwrite)
                    next_state = ST_WWAIT;
                else if (valid)
                    next_state = ST_READ;
                else
                    next_state = ST_IDLE;
            end
            ST_WENABLEP: begin
                // A pipelined write was already accepted; its address and
                // data are now two/one cycles old respectively.
                if (!hwrite_reg)
                    next_state = ST_READ;
                else if (valid)
                    next_state = ST_WRITEP;
                else
                    next_state = ST_WRITE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register and registered APB/AHB outputs keyed on (state, next_state).
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= ST_IDLE;
            pwrite    <= 1'b0;
            penable   <= 1'b0;
            pselx     <= 3'b000;
            paddr     <= 32'h0;
            pwdata    <= 32'h0;
            hreadyout <= 1'b1;
        end else begin
            state <= next_state;
            case (next_state)
                ST_IDLE: begin
                    pselx     <= 3'b000;
                    penable   <= 1'b0;
                    pwrite    <= 1'b0;
                    hreadyout <= 1'b1;
                end
                ST_WWAIT: begin
                    // Wait for the write data phase; address/data/direction held.
                    pselx     <= 3'b000;
                    penable   <= 1'b0;
                    hreadyout <= 1'b1;
                end
                ST_READ: begin
                    // After a pipelined write, the read address is two cycles old.
                    paddr     <= (state == ST_WENABLEP) ? haddr2 : haddr;
                    pwrite    <= 1'b0;
                    pselx     <= temp_selx;
                    penable   <= 1'b0;
                    hreadyout <= 1'b0;
                end
                ST_WRITE, ST_WRITEP: begin
                    if (state == ST_WENABLEP) begin
                        paddr  <= haddr2;
                        pwdata <= hwdata1;
                    end else begin
                        paddr  <= haddr1;
                        pwdata <= hwdata;
                    end
                    pwrite    <= 1'b1;
                    pselx     <= temp_selx;
                    penable   <= 1'b0;
                    hreadyout <= 1'b0;
                end
                ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                    // Access phase: select, address, data and direction held.
                    penable   <= 1'b1;
                    hreadyout <= 1'b1;
                end
                default: begin
                    pwrite    <= 1'b0;
                    penable   <= 1'b0;
                    pselx     <= 3'b000;
                    paddr     <= 32'h0;
                    pwdata    <= 32'h0;
                    hreadyout <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Bench for apb_fsm_controller: a table of per-cycle AHB inputs with
// hand-derived expected state/outputs, plus reset sequences.
`timescale 1ns/1ps
module tb_apb_fsm_controller;

    localparam logic [2:0] S_IDLE = 3'd0, S_WWAIT = 3'd1, S_READ = 3'd2, S_WRITE = 3'd3,
                           S_WRITEP = 3'd4, S_RENABLE = 3'd5, S_WENABLE = 3'd6, S_WENABLEP = 3'd7;

    logic        hclk, hresetn, valid, hwrite, hwrite_reg;
    logic [31:0] haddr, haddr1, haddr2, hwdata, hwdata1, hwdata2;
    logic [2:0]  temp_selx;
    logic        pwrite, penable, hreadyout;
    logic [2:0]  pselx, fsm_state;
    logic [31:0] paddr, pwdata;

    typedef struct {
        logic        v;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  s;
        logic [72:0] exp;
        string       nm;
    } vec_t;

    vec_t        tbl[$];
    logic [72:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    apb_fsm_controller dut (
        .hclk(hclk), .hresetn(hresetn), .valid(valid), .hwrite(hwrite),
        .hwrite_reg(hwrite_reg), .haddr(haddr), .haddr1(haddr1), .haddr2(haddr2),
        .hwdata(hwdata), .hwdata1(hwdata1), .hwdata2(hwdata2), .temp_selx(temp_selx),
        .pwrite(pwrite), .penable(penable), .pselx(pselx), .paddr(paddr),
        .pwdata(pwdata), .hreadyout(hreadyout), .fsm_state(fsm_state)
    );

    // Clock and watchdog.
    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [72:0] pk(input logic [2:0] st, input logic pw, input logic pe,
                                        input logic [2:0] sel, input logic [31:0] pa,
                                        input logic [31:0] pd, input logic hr);
        return {st, pw, pe, sel, pa, pd, hr};
    endfunction

    function automatic void add(input logic v, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [2:0] s, input logic [72:0] e,
                                input string nm);
        vec_t r;
        r.v = v; r.w = w; r.a = a; r.d = d; r.s = s; r.exp = e; r.nm = nm;
        tbl.push_back(r);
    endfunction

    // Driver: at the falling edge, advance the upstream delay pipeline, then drive.
    task automatic drive(input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] s);
        @(negedge hclk);
        hwrite_reg = hwrite;
        haddr2 = haddr1;   haddr1 = haddr;
        hwdata2 = hwdata1; hwdata1 = hwdata;
        valid = v; hwrite = w; haddr = a; hwdata = d; temp_selx = s;
    endtask

    // Scoreboard check: pop the oldest expectation and compare against the DUT.
    task automatic sample(input string nm);
        logic [72:0] act;
        logic [72:0] e;
        act = {fsm_state, pwrite, penable, pselx, paddr, pwdata, hreadyout};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: no expectation queued, actual=%h", nm, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_err++;
                $display("FAIL %s: actual st=%0d pw=%0b pe=%0b sel=%b pa=%h pd=%h hr=%0b required st=%0d pw=%0b pe=%0b sel=%b pa=%h pd=%h hr=%0b",
                         nm, act[72:70], act[69], act[68], act[67:65], act[64:33], act[32:1], act[0],
                         e[72:70], e[69], e[68], e[67:65], e[64:33], e[32:1], e[0]);
            end
        end
    endtask

    task automatic apply(input vec_t r);
        drive(r.v, r.w, r.a, r.d, r.s);
        exp_q.push_back(r.exp);
        @(posedge hclk);
        #1;
        sample(r.nm);
    endtask

    initial begin
        logic [72:0] rst_v;
        rst_v = pk(S_IDLE, 0, 0, 3'b000, 32'h0, 32'h0, 1);

        hresetn = 1'b1; valid = 0; hwrite = 0; hwrite_reg = 0;
        haddr = 0; haddr1 = 0; haddr2 = 0; hwdata = 0; hwdata1 = 0; hwdata2 = 0;
        temp_selx = 3'b000;

        // Idle transfers.
        for (int i = 0; i < 10; i++)
            add(0, 0, 32'h0, 32'h0, 3'b000, pk(S_IDLE, 0, 0, 3'b000, 32'h0, 32'h0, 1), $sformatf("idle%0d", i));
        // Single read.
        add(1, 0, 32'h8000_0002, 32'h0, 3'b001, pk(S_READ,    0, 0, 3'b001, 32'h8000_0002, 32'h0, 0), "rd_setup");
        add(0, 0, 32'h0,         32'h0, 3'b001, pk(S_RENABLE, 0, 1, 3'b001, 32'h8000_0002, 32'h0, 1), "rd_access");
        add(0, 0, 32'h0,         32'h0, 3'b000, pk(S_IDLE,    0, 0, 3'b000, 32'h8000_0002, 32'h0, 1), "rd_idle");
        // Single write.
        add(1, 1, 32'h8000_0003, 32'h0,  3'b001, pk(S_WWAIT,   0, 0, 3'b000, 32'h8000_0002, 32'h0,  1), "wr_wait");
        add(0, 0, 32'h0,         32'h73, 3'b001, pk(S_WRITE,   1, 0, 3'b001, 32'h8000_0003, 32'h73, 0), "wr_setup");
        add(0, 0, 32'h0,         32'h0,  3'b001, pk(S_WENABLE, 1, 1, 3'b001, 32'h8000_0003, 32'h73, 1), "wr_access");
        add(0, 0, 32'h0,         32'h0,  3'b000, pk(S_IDLE,    0, 0, 3'b000, 32'h8000_0003, 32'h73, 1), "wr_idle");
        // Burst of three writes.
        add(1, 1, 32'h8000_0002, 32'h0,  3'b010, pk(S_WWAIT,    0, 0, 3'b000, 32'h8000_0003, 32'h73, 1), "bw_wait");
        add(1, 1, 32'h8000_0003, 32'h28, 3'b010, pk(S_WRITEP,   1, 0, 3'b010, 32'h8000_0002, 32'h28, 0), "bw_setup1");
        add(1, 1, 32'h8000_0004, 32'h73, 3'b010, pk(S_WENABLEP, 1, 1, 3'b010, 32'h8000_0002, 32'h28, 1), "bw_access1");
        add(1, 1, 32'h8000_0004, 32'h73, 3'b010, pk(S_WRITEP,   1, 0, 3'b010, 32'h8000_0003, 32'h73, 0), "bw_setup2");
        add(0, 1, 32'h8000_0004, 32'h89, 3'b010, pk(S_WENABLEP, 1, 1, 3'b010, 32'h8000_0003, 32'h73, 1), "bw_access2");
        add(0, 0, 32'h0,         32'h0,  3'b010, pk(S_WRITE,    1, 0, 3'b010, 32'h8000_0004, 32'h89, 0), "bw_setup3");
        add(0, 0, 32'h0,         32'h0,  3'b010, pk(S_WENABLE,  1, 1, 3'b010, 32'h8000_0004, 32'h89, 1), "bw_access3");
        add(0, 0, 32'h0,         32'h0,  3'b000, pk(S_IDLE,     0, 0, 3'b000, 32'h8000_0004, 32'h89, 1), "bw_idle");
        // Write immediately followed by a read.
        add(1, 1, 32'h8000_0004, 32'h0,  3'b100, pk(S_WWAIT,    0, 0, 3'b000, 32'h8000_0004, 32'h89, 1), "wr2rd_wait");
        add(1, 0, 32'h8000_0005, 32'h5A, 3'b100, pk(S_WRITEP,   1, 0, 3'b100, 32'h8000_0004, 32'h5A, 0), "wr2rd_wsetup");
        add(1, 0, 32'h8000_0005, 32'h0,  3'b100, pk(S_WENABLEP, 1, 1, 3'b100, 32'h8000_0004, 32'h5A, 1), "wr2rd_waccess");
        add(0, 0, 32'h0,         32'h0,  3'b100, pk(S_READ,     0, 0, 3'b100, 32'h8000_0005, 32'h5A, 0), "wr2rd_rsetup");
        add(0, 0, 32'h0,         32'h0,  3'b100, pk(S_RENABLE,  0, 1, 3'b100, 32'h8000_0005, 32'h5A, 1), "wr2rd_raccess");
        add(0, 0, 32'h0,         32'h0,  3'b000, pk(S_IDLE,     0, 0, 3'b000, 32'h8000_0005, 32'h5A, 1), "wr2rd_idle");
        // Back-to-back reads, read->write, write->pipelined read.
        add(1, 0, 32'h8000_0010, 32'h0,          3'b001, pk(S_READ,     0, 0, 3'b001, 32'h8000_0010, 32'h5A,         0), "rr_setup1");
        add(0, 0, 32'h0,         32'h0,          3'b001, pk(S_RENABLE,  0, 1, 3'b001, 32'h8000_0010, 32'h5A,         1), "rr_access1");
        add(1, 0, 32'h8000_0020, 32'h0,          3'b010, pk(S_READ,     0, 0, 3'b010, 32'h8000_0020, 32'h5A,         0), "rr_setup2");
        add(0, 0, 32'h0,         32'h0,          3'b010, pk(S_RENABLE,  0, 1, 3'b010, 32'h8000_0020, 32'h5A,         1), "rr_access2");
        add(1, 1, 32'h8000_0030, 32'h0,          3'b100, pk(S_WWAIT,    0, 0, 3'b000, 32'h8000_0020, 32'h5A,         1), "rw_wait");
        add(0, 0, 32'h8000_0040, 32'hDEAD_BEEF,  3'b100, pk(S_WRITE,    1, 0, 3'b100, 32'h8000_0030, 32'hDEAD_BEEF,  0), "rw_wsetup");
        add(1, 0, 32'h8000_0040, 32'h0,          3'b001, pk(S_WENABLEP, 1, 1, 3'b100, 32'h8000_0030, 32'hDEAD_BEEF,  1), "rw_waccess");
        add(0, 0, 32'h0,         32'h0,          3'b001, pk(S_READ,     0, 0, 3'b001, 32'h8000_0040, 32'hDEAD_BEEF,  0), "rw_rsetup");
        add(0, 0, 32'h0,         32'h0,          3'b001, pk(S_RENABLE,  0, 1, 3'b001, 32'h8000_0040, 32'hDEAD_BEEF,  1), "rw_raccess");
        add(0, 0, 32'h0,         32'h0,          3'b000, pk(S_IDLE,     0, 0, 3'b000, 32'h8000_0040, 32'hDEAD_BEEF,  1), "rw_idle");
        // WENABLE exits to WWAIT and to READ.
        add(1, 1, 32'h8000_0050, 32'h0,  3'b010, pk(S_WWAIT,   0, 0, 3'b000, 32'h8000_0040, 32'hDEAD_BEEF, 1), "ww_wait1");
        add(0, 0, 32'h0,         32'h11, 3'b010, pk(S_WRITE,   1, 0, 3'b010, 32'h8000_0050, 32'h11, 0), "ww_setup1");
        add(0, 0, 32'h0,         32'h0,  3'b010, pk(S_WENABLE, 1, 1, 3'b010, 32'h8000_0050, 32'h11, 1), "ww_access1");
        add(1, 1, 32'h8000_0060, 32'h0,  3'b010, pk(S_WWAIT,   1, 0, 3'b000, 32'h8000_0050, 32'h11, 1), "ww_wait2");
        add(0, 0, 32'h0,         32'h22, 3'b010, pk(S_WRITE,   1, 0, 3'b010, 32'h8000_0060, 32'h22, 0), "ww_setup2");
        add(0, 0, 32'h0,         32'h0,  3'b010, pk(S_WENABLE, 1, 1, 3'b010, 32'h8000_0060, 32'h22, 1), "ww_access2");
        add(1, 0, 32'h8000_0070, 32'h0,  3'b100, pk(S_READ,    0, 0, 3'b100, 32'h8000_0070, 32'h22, 0), "wr_rsetup");
        add(0, 0, 32'h0,         32'h0,  3'b100, pk(S_RENABLE, 0, 1, 3'b100, 32'h8000_0070, 32'h22, 1), "wr_raccess");
        add(0, 0, 32'h0,         32'h0,  3'b000, pk(S_IDLE,    0, 0, 3'b000, 32'h8000_0070, 32'h22, 1), "wr_ridle");

        // Power-on reset, checked before any clock edge can act.
        #3 hresetn = 1'b0;
        #1;
        exp_q.push_back(rst_v);
        sample("por_async");
        @(posedge hclk); @(posedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i]);

        // Reset asserted while a write is in its setup phase.
        drive(1, 1, 32'h8000_0080, 32'h0, 3'b001);
        exp_q.push_back(pk(S_WWAIT, 0, 0, 3'b000, 32'h8000_0070, 32'h22, 1));
        @(posedge hclk); #1; sample("rst_wait");
        drive(0, 0, 32'h0, 32'hAB, 3'b001);
        exp_q.push_back(pk(S_WRITE, 1, 0, 3'b001, 32'h8000_0080, 32'hAB, 0));
        @(posedge hclk); #1; sample("rst_wsetup");
        drive(0, 0, 32'h0, 32'h0, 3'b001);
        hresetn = 1'b0;
        #1;
        exp_q.push_back(rst_v);
        sample("rst_async");
        @(posedge hclk); #1;
        exp_q.push_back(rst_v);
        sample("rst_held");
        // Release with a read pending: first edge after release must act on it.
        drive(1, 0, 32'h8000_0090, 32'h0, 3'b010);
        hresetn = 1'b1;
        exp_q.push_back(pk(S_READ, 0, 0, 3'b010, 32'h8000_0090, 32'h0, 0));
        @(posedge hclk); #1; sample("post_rst_rsetup");
        drive(0, 0, 32'h0, 32'h0, 3'b010);
        exp_q.push_back(pk(S_RENABLE, 0, 1, 3'b010, 32'h8000_0090, 32'h0, 1));
        @(posedge hclk); #1; sample("post_rst_raccess");
        drive(0, 0, 32'h0, 32'h0, 3'b000);
        exp_q.push_back(pk(S_IDLE, 0, 0, 3'b000, 32'h8000_0090, 32'h0, 1));
        @(posedge hclk); #1; sample("post_rst_idle");

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL leftover: actual=%0d queued expectations required=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
